// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry and a
// microsecond-to-cycle conversion used to size timers from clock frequency.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_RECOVER
  } ps2_state_t;

  // A host frame is start + 8 data + parity + stop, plus the device's ack edge.
  localparam int PS2_FRAME_EDGES = 11;
  localparam int PS2_DATA_BITS   = 8;

  // 64-bit intermediate keeps long timeouts at high clock rates from overflowing.
  function automatic int us_to_cycles(input longint clk_hz, input longint us);
    return int'((clk_hz * us) / 64'sd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detect for one PS/2 line.
// Flops reset high because idle PS/2 lines are pulled up.
module ps2_line_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic line_in,
  output logic sync_out,
  output logic fall_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw line through the metastability stages and keep one old sample.
  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign fall_out = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts out {parity, data} on device clock falls, checks the ack bit and
// reports done or error exactly once per accepted byte.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 100_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe_out,
  output logic       ps2_data_oe_out
);

  localparam int INHIBIT_CYC = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(INHIBIT_US));
  localparam int START_CYC   = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(START_TIMEOUT_US));
  localparam int FRAME_CYC   = us_to_cycles(longint'(CLK_FREQ_HZ), longint'(FRAME_TIMEOUT_US));
  localparam int MAX_A       = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam int MAX_CYC     = (MAX_A > INHIBIT_CYC) ? MAX_A : INHIBIT_CYC;
  localparam int CNT_W       = $clog2(MAX_CYC + 1);

  // Terminal counts are compared against the value held during the last cycle.
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;

  // Fall count at which the parity bit has just gone out; the next fall is the stop bit.
  localparam logic [3:0] PARITY_EDGE = 4'(PS2_DATA_BITS + 1);
  localparam logic [3:0] STOP_EDGE   = 4'(PS2_FRAME_EDGES - 1);
  localparam logic [3:0] ACK_EDGE    = 4'(PS2_FRAME_EDGES);

  logic sync_clk, clk_fall;
  logic sync_data, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .line_in  (ps2_clk_in),
    .sync_out (sync_clk),
    .fall_out (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .line_in  (ps2_data_in),
    .sync_out (sync_data),
    .fall_out (data_fall_unused)
  );

  ps2_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  // Next-state, line-drive and status logic; timeouts take priority over falls.
  always_comb begin
    cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    state_d   = state_q;
    cnt_d     = cnt_inc;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (valid_in) begin
          shift_d   = {~^data_in, data_in};
          cnt_d     = '0;
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RTS;
        end
      end
      ST_RTS: begin
        if (cnt_q == START_LAST) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_RECOVER;
        end else if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          bit_cnt_d = 4'd1;
          cnt_d     = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == FRAME_LAST) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_RECOVER;
        end else if (clk_fall) begin
          if (bit_cnt_q == PARITY_EDGE) begin
            data_oe_d = 1'b0;
            bit_cnt_d = STOP_EDGE;
            state_d   = ST_ACK;
          end else begin
            shift_d   = {1'b0, shift_q[8:1]};
            data_oe_d = ~shift_q[1];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (cnt_q == FRAME_LAST) begin
          error_d = 1'b1;
          state_d = ST_RECOVER;
        end else if (clk_fall) begin
          bit_cnt_d = ACK_EDGE;
          if (!sync_data) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_RECOVER;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (cnt_q == FRAME_LAST) begin
          error_d = 1'b1;
          state_d = ST_RECOVER;
        end else if (sync_clk && sync_data) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ready_out       = ready_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign error_out       = error_q;
  assign ps2_clk_oe_out  = clk_oe_q;
  assign ps2_data_oe_out = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural PS/2 device on open-drain lines, frame
// reference computed from byte value, timing and error-path checks.
module tb_ps2_tx;

  localparam int CLK_HZ    = 1_000_000;
  localparam int INH_US    = 100;
  localparam int START_US  = 15000;
  localparam int FRAME_US  = 2000;
  localparam int CYC_PER_US = CLK_HZ / 1_000_000;
  localparam int INH_CYC   = INH_US * CYC_PER_US;
  localparam int START_CYC = START_US * CYC_PER_US;
  localparam int FRAME_CYC = FRAME_US * CYC_PER_US;
  localparam int HALF      = 40;  // 12.5 kHz device clock at 1 MHz system clock

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, busy_out, done_out, error_out;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe_out, ps2_data_oe_out;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain wired-AND of host and device
  assign ps2_clk_in  = ~(ps2_clk_oe_out | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe_out | dev_data_low);

  ps2_tx #(
    .CLK_FREQ_HZ      (CLK_HZ),
    .INHIBIT_US       (INH_US),
    .START_TIMEOUT_US (START_US),
    .FRAME_TIMEOUT_US (FRAME_US)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out),
    .ps2_clk_in      (ps2_clk_in),
    .ps2_data_in     (ps2_data_in),
    .ps2_clk_oe_out  (ps2_clk_oe_out),
    .ps2_data_oe_out (ps2_data_oe_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor on the inactive edge
  int   cyc = 0;
  int   t_inh = 0, t_rts = 0, t_err = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic prev_clk_oe = 1'b0;

  always @(negedge clk_in) begin
    cyc++;
    if (ps2_clk_oe_out && !prev_clk_oe) t_inh = cyc;
    if (!ps2_clk_oe_out && prev_clk_oe && ps2_data_oe_out) t_rts = cyc;
    if (done_out) done_cnt++;
    if (error_out) begin
      err_cnt++;
      t_err = cyc;
    end
    if (done_out && error_out) both_cnt++;
    prev_clk_oe = ps2_clk_oe_out;
  end

  // Reference frame as the device should read it: start, LSB-first data, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_in);
    while (!ready_out && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready_out) check_val("ready_wait", 32'(ready_out), 32'd1);
    data_in  = b;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    check_val("busy_after_accept", 32'(busy_out), 32'd1);
    check_val("ready_after_accept", 32'(ready_out), 32'd0);
  endtask

  // Device: waits for request-to-send, clocks max_falls pulses, reads on rising edges
  task automatic dev_run(input int max_falls, input bit do_ack,
                         output logic [10:0] bits, output bit rts_ok);
    int n;
    n      = 0;
    bits   = '1;
    rts_ok = 1'b0;
    while (!(ps2_data_oe_out && !ps2_clk_oe_out) && n < INH_CYC + 100) begin
      @(negedge clk_in);
      n++;
    end
    if (!(ps2_data_oe_out && !ps2_clk_oe_out)) return;
    rts_ok = 1'b1;
    repeat (HALF) @(negedge clk_in);
    bits[0] = ps2_data_in;
    for (int k = 1; k <= max_falls; k++) begin
      if (k == 11 && do_ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk_in);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_in);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = ps2_data_in;
      repeat (HALF) @(negedge clk_in);
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_out && n < FRAME_CYC + START_CYC) begin
      @(negedge clk_in);
      n++;
    end
    check_val({tag, "_ready"}, 32'(ready_out), 32'd1);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input bit poke, input string tag);
    int d0, e0;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    if (poke) begin
      data_in  = 8'h55;
      valid_in = 1'b1;
      repeat (5) @(negedge clk_in);
      valid_in = 1'b0;
    end
    dev_run(11, ack, bits, ok);
    check_val({tag, "_rts"}, 32'(ok), 32'd1);
    check_val({tag, "_bits"}, 32'(bits), 32'(frame_of(b)));
    wait_ready(tag);
    check_val({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check_val({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, n, dt;
    logic [10:0] bits;
    bit ok;

    // Reset values
    repeat (3) @(negedge clk_in);
    check_val("rst_ready", 32'(ready_out), 32'd1);
    check_val("rst_busy", 32'(busy_out), 32'd0);
    check_val("rst_oe", 32'({ps2_clk_oe_out, ps2_data_oe_out, done_out, error_out}), 32'd0);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // 0xED with a valid request during the frame that must be ignored
    run_frame(8'hED, 1'b1, 1'b1, "ed");
    dt = t_rts - t_inh;
    check_val("inhibit_len", 32'((dt >= INH_CYC - 1 && dt <= INH_CYC + 1) ? INH_CYC : dt), 32'(INH_CYC));

    run_frame(8'h00, 1'b1, 1'b0, "zero");

    // Device never clocks
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'hF4);
    n = 0;
    while (err_cnt == e0 && n < START_CYC + INH_CYC + 200) begin
      @(negedge clk_in);
      n++;
    end
    check_val("start_to_err", 32'(err_cnt - e0), 32'd1);
    dt = t_err - t_rts;
    check_val("start_to_time", 32'((dt >= START_CYC - 2 && dt <= START_CYC + 2) ? START_CYC : dt), 32'(START_CYC));
    check_val("start_to_oe", 32'({ps2_clk_oe_out, ps2_data_oe_out}), 32'd0);
    wait_ready("start_to");
    check_val("start_to_done", 32'(done_cnt - d0), 32'd0);

    // Withheld ack
    run_frame(8'hFF, 1'b0, 1'b0, "noack");

    // Device stalls mid-frame
    e0 = err_cnt;
    d0 = done_cnt;
    send_byte(8'h3C);
    dev_run(5, 1'b1, bits, ok);
    n = 0;
    while (err_cnt == e0 && n < FRAME_CYC + 200) begin
      @(negedge clk_in);
      n++;
    end
    check_val("frame_to_err", 32'(err_cnt - e0), 32'd1);
    wait_ready("frame_to");
    check_val("frame_to_done", 32'(done_cnt - d0), 32'd0);

    // Asynchronous reset after fall 4
    send_byte(8'h00);
    dev_run(4, 1'b1, bits, ok);
    check_val("pre_rst_data_oe", 32'(ps2_data_oe_out), 32'd1);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check_val("mid_rst_oe", 32'({ps2_clk_oe_out, ps2_data_oe_out}), 32'd0);
    check_val("mid_rst_status", 32'({ready_out, busy_out, done_out, error_out}), 32'b1000);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    run_frame(8'hA5, 1'b1, 1'b0, "post_rst");

    // Randomized bytes and ack behaviour
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      bit ack;
      b   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      run_frame(b, ack, 1'b0, $sformatf("rnd%0d", i));
    end

    check_val("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter: the transmit direction of the keyboard link, complementing the existing ps2_rx receiver on pmodb.
- Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the open-drain clock/data lines via output-enable signals; the top level maps them to IOBUF tristates.
- Exposes busy_out so ps2_rx can be gated while a host frame is on the wire.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clk_in frequency.
- INHIBIT_US, 100, time ps2 clock is held low before request-to-send.
- START_TIMEOUT_US, 15000, max wait for the device's first clock falling edge after release.
- FRAME_TIMEOUT_US, 2000, max time from first falling edge to ack edge.

Ports:
- clk_in  input  1  system clock (clk_100mhz).
- rst_in  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to send.
- valid_in  input  1  request; byte accepted when valid_in && ready_out.
- ready_out  output  1  high only in IDLE.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse: frame acknowledged by device.
- error_out  output  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  input  1  raw ps2 clock line (async).
- ps2_data_in  input  1  raw ps2 data line (async).
- ps2_clk_oe_out  output  1  1 = pull clock line low, 0 = release.
- ps2_data_oe_out  output  1  1 = pull data line low, 0 = release.

Behaviour:
- Reset (rst_in low, async): state IDLE, ready_out=1, busy_out=0, done_out=0, error_out=0, both oe outputs 0, counters and shift register 0. Synchronizers reset to 1 (idle-high lines).
- Inputs: ps2_clk_in and ps2_data_in each pass a 2-flop synchronizer. fall = sync_clk_prev & ~sync_clk. Edge detection adds 3 cycles of latency; this is acceptable at 10-16.7 kHz.
- Accept: in IDLE with valid_in=1, latch {odd parity bit, data_in} into a 9-bit shift register. Odd parity = ~^data_in. Zero the cycle counter. Go to INHIBIT. valid_in outside IDLE is ignored, with no queueing.
- INHIBIT: clk_oe=1, data_oe=0. After INHIBIT_US*CLK_FREQ_HZ/1e6 cycles (10_000 at default), set data_oe=1 (start bit), zero the counter and go to RTS.
- RTS: clk_oe=0, data_oe=1. The first fall puts bit 0 on the line (data_oe = ~shift[0]), sets bit_cnt=1, zeroes the counter and goes to SEND. If the counter reaches START_TIMEOUT cycles: error, go to RECOVER.
- SEND: on each fall, shift right and drive data_oe = ~shift[0]. Falls 2..8 send data bits 1..7; fall 9 sends parity. Fall 10 sets data_oe=0 (stop bit, released) and enters ACK.
- ACK: on fall 11, sample sync_data. If it is 0 the device has acked: go to WAIT_IDLE. If it is 1: error, go to RECOVER.
- FRAME_TIMEOUT spans SEND+ACK and is measured from the first fall. On expiry: error, go to RECOVER.
- WAIT_IDLE: both oe=0. Wait until sync_clk=1 and sync_data=1, then pulse done_out and go to IDLE. Also bounded by FRAME_TIMEOUT; on expiry: error, go to RECOVER.
- RECOVER: both oe=0. Pulse error_out for one cycle, go to IDLE.
- Counter: width $clog2 of the largest timeout in cycles. It saturates and never wraps.
- Simultaneous events: a timeout and a fall in the same cycle resolve as timeout.
- Reset mid-frame releases both lines immediately, asynchronously.
- done_out and error_out are mutually exclusive; exactly one pulses per accepted byte.

Decomposition:
- ps2_pkg holds:
  - the state enum typedef (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, RECOVER);
  - a function converting microseconds to cycles;
  - the frame-length constants (11 edges, 8 data bits).
- ps2_rx is refactored to import ps2_pkg.
- One sub-module, ps2_line_sync: 2-flop synchronizer plus falling-edge detect for one line. It is instantiated twice here and reused by ps2_rx.

Test Plan:
- Send 0xED. Device model clocks at 12.5 kHz and samples on rising edges. Required: it reads start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks; done_out pulses once, ready_out returns to 1.
- Send 0x00. Required: parity bit 1, ack received, done_out=1, error_out never asserted.
- INHIBIT timing: clk_oe high for exactly 10_000 cycles (±1) before data_oe rises. busy_out is high from the accept cycle onward.
- Device never clocks. Required: error_out pulses 1,500,000 cycles after RTS entry, both oe=0, ready_out=1.
- Device withholds ack (data high at fall 11). Required: error_out pulses, done_out stays 0.
- Assert rst_in low mid-SEND (after fall 4). Required: both oe outputs 0 the same cycle, outputs at reset values, next valid_in accepted normally.
